// File: rtl/world_clock_pkg.sv
// -----------------------------------------------------------------------------
// world_clock_pkg
// Shared constants and types for the world-clock blocks.
//   HOUR_W        : width of an hour value (0..23 fits in 5 bits)
//   HOURS_PER_DAY : wrap modulus for local-time arithmetic
//   OFFSET_MIN/MAX: legal range of a per-city UTC offset, in hours
//   DAY_W         : width of the signed day-shift field
//   sched_state_t : scheduler FSM states
//   DAY_*         : day-shift encodings (two's complement, 2 bits)
// -----------------------------------------------------------------------------
package world_clock_pkg;

   localparam int HOUR_W        = 5;
   localparam int HOURS_PER_DAY = 24;
   localparam int OFFSET_MIN    = -12;
   localparam int OFFSET_MAX    = 14;
   localparam int DAY_W         = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } sched_state_t;

   localparam logic [DAY_W-1:0] DAY_MINUS = 2'b11;
   localparam logic [DAY_W-1:0] DAY_SAME  = 2'b00;
   localparam logic [DAY_W-1:0] DAY_PLUS  = 2'b01;

   // True when a two's-complement offset lies inside the legal zone range.
   function automatic logic offset_in_range(input logic [HOUR_W-1:0] off);
      int v;
      v = int'($signed(off));
      return (v >= OFFSET_MIN) && (v <= OFFSET_MAX);
   endfunction

endpackage

// File: rtl/hour12_24.sv
// -----------------------------------------------------------------------------
// hour12_24
// Combinational 24h -> display-hour converter.
//   hour_24   in  local hour 0..23
//   mode_12h  in  1 = 12-hour display
//   hour_disp out displayed hour (12h mode: 0..12, hour 0 stays 0)
//   is_pm     out PM flag (only ever set in 12-hour mode)
// -----------------------------------------------------------------------------
module hour12_24
   import world_clock_pkg::*;
(
   input  logic [HOUR_W-1:0] hour_24,
   input  logic              mode_12h,
   output logic [HOUR_W-1:0] hour_disp,
   output logic              is_pm
);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      hour_disp = hour_24;
      is_pm     = 1'b0;
      if (mode_12h && (hour_24 >= HOUR_W'(12))) begin
         is_pm = 1'b1;
         if (hour_24 > HOUR_W'(12)) begin
            hour_disp = hour_24 - HOUR_W'(12);
         end
      end
   end

endmodule

// File: rtl/tz_hour_scheduler.sv
// -----------------------------------------------------------------------------
// tz_hour_scheduler
// Holds a per-city UTC offset table and sweeps the slots one per cycle through
// a single shared 12/24 converter, producing per-slot local hour, PM flag and
// day shift. Owns the global 12/24 display mode.
//   clk, rst    : clock, synchronous active-high reset
//   utc_hour    : current UTC hour (>= 24 is treated as 0)
//   tick        : UTC hour changed (starts a sweep)
//   mode_btn    : toggles 12/24 mode (starts a sweep)
//   cfg_we/idx/offset : offset-table write; out-of-range writes are dropped
//   mode_12h    : current mode, 1 = 12-hour
//   hour_disp   : slot k at [5k+4:5k]
//   is_pm       : per-slot PM flag
//   day_off     : per-slot signed day shift at [2k+1:2k]
//   busy        : sweep in progress
//   done        : one-cycle pulse at end of sweep
// -----------------------------------------------------------------------------
module tz_hour_scheduler
   import world_clock_pkg::*;
#(
   parameter int N_CITY = 4,
   parameter int IDX_W  = $clog2(N_CITY)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [HOUR_W-1:0]        utc_hour,
   input  logic                     tick,
   input  logic                     mode_btn,
   input  logic                     cfg_we,
   input  logic [IDX_W-1:0]         cfg_idx,
   input  logic [HOUR_W-1:0]        cfg_offset,
   output logic                     mode_12h,
   output logic [HOUR_W*N_CITY-1:0] hour_disp,
   output logic [N_CITY-1:0]        is_pm,
   output logic [DAY_W*N_CITY-1:0]  day_off,
   output logic                     busy,
   output logic                     done
);

   localparam int                       SUM_W       = HOUR_W + 2;
   localparam logic [IDX_W-1:0]         LAST_IDX    = IDX_W'(N_CITY - 1);
   localparam logic [IDX_W:0]           N_CITY_V    = (IDX_W + 1)'(N_CITY);
   localparam logic [HOUR_W-1:0]        DAY_HOURS_U = HOUR_W'(HOURS_PER_DAY);
   localparam logic signed [SUM_W-1:0]  DAY_HOURS_S = SUM_W'(HOURS_PER_DAY);

   // Offset table (two's-complement hours) and per-slot result registers.
   logic [HOUR_W-1:0] offset_tab [N_CITY];
   logic [HOUR_W-1:0] disp_r     [N_CITY];
   logic              pm_r       [N_CITY];
   logic [DAY_W-1:0]  day_r      [N_CITY];

   sched_state_t      state;
   logic [IDX_W-1:0]  idx;
   logic [HOUR_W-1:0] utc_lat;
   logic              mode_lat;
   logic              pending;

   logic                    cfg_ok;
   logic                    ext_event;
   logic                    mode_next;
   logic [HOUR_W-1:0]       utc_clean;
   logic [HOUR_W-1:0]       cur_off;
   logic signed [SUM_W-1:0] sum;
   logic [HOUR_W-1:0]       local_hour;
   logic [DAY_W-1:0]        slot_day;
   logic [HOUR_W-1:0]       conv_disp;
   logic                    conv_pm;

   // Event decode. An out-of-range write is not an event at all.
   always_comb begin
      cfg_ok    = cfg_we && ({1'b0, cfg_idx} < N_CITY_V) && offset_in_range(cfg_offset);
      ext_event = tick || mode_btn || cfg_ok;
      // Mode the next sweep must use: the toggle lands on the same edge.
      mode_next = mode_12h ^ mode_btn;
      utc_clean = (utc_hour < DAY_HOURS_U) ? utc_hour : '0;
   end

   // Wrap arithmetic for the slot being computed. The table is read live, so
   // a write landing mid-sweep affects the slots not yet visited.
   always_comb begin
      cur_off    = offset_tab[idx];
      sum        = $signed({2'b00, utc_lat}) +
                   $signed({{2{cur_off[HOUR_W-1]}}, cur_off});
      local_hour = sum[HOUR_W-1:0];
      slot_day   = DAY_SAME;
      if (sum[SUM_W-1]) begin
         local_hour = HOUR_W'(sum + DAY_HOURS_S);
         slot_day   = DAY_MINUS;
      end else if (sum >= DAY_HOURS_S) begin
         local_hour = HOUR_W'(sum - DAY_HOURS_S);
         slot_day   = DAY_PLUS;
      end
   end

   hour12_24 u_conv (
      .hour_24   (local_hour),
      .mode_12h  (mode_lat),
      .hour_disp (conv_disp),
      .is_pm     (conv_pm)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         idx      <= '0;
         utc_lat  <= '0;
         mode_lat <= 1'b0;
         pending  <= 1'b1;          // forces one sweep after reset release
         mode_12h <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         // NOTE: the table and result arrays are reset explicitly; a reset
         // mid-sweep must clear partially written slots and zero all offsets.
         for (int k = 0; k < N_CITY; k++) begin
            offset_tab[k] <= '0;
            disp_r[k]     <= '0;
            pm_r[k]       <= 1'b0;
            day_r[k]      <= DAY_SAME;
         end
      end else begin
         done <= 1'b0;

         if (mode_btn) begin
            mode_12h <= ~mode_12h;
         end
         if (cfg_ok) begin
            offset_tab[cfg_idx] <= cfg_offset;
         end

         case (state)
            ST_IDLE: begin
               if (ext_event || pending) begin
                  state    <= ST_CALC;
                  busy     <= 1'b1;
                  utc_lat  <= utc_clean;
                  mode_lat <= mode_next;
                  idx      <= '0;
                  pending  <= 1'b0;
               end
            end

            ST_CALC: begin
               disp_r[idx] <= conv_disp;
               pm_r[idx]   <= conv_pm;
               day_r[idx]  <= slot_day;
               if (ext_event) begin
                  pending <= 1'b1;
               end
               if (idx == LAST_IDX) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end else begin
                  idx <= idx + 1'b1;
               end
            end

            ST_DONE: begin
               if (pending) begin
                  // Back-to-back sweep with fresh inputs, no IDLE cycle.
                  state    <= ST_CALC;
                  utc_lat  <= utc_clean;
                  mode_lat <= mode_next;
                  idx      <= '0;
                  pending  <= 1'b0;
               end else begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  if (ext_event) begin
                     pending <= 1'b1;
                  end
               end
            end

            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Flatten the per-slot registers onto the packed output buses.
   for (genvar k = 0; k < N_CITY; k++) begin : g_flat
      assign hour_disp[HOUR_W*k +: HOUR_W] = disp_r[k];
      assign is_pm[k]                      = pm_r[k];
      assign day_off[DAY_W*k +: DAY_W]     = day_r[k];
   end

endmodule

// File: tb/tb_tz_hour_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tz_hour_scheduler
// Self-checking bench: reset and post-reset sweep, a table of directed
// vectors, hand-written multi-cycle sequences, randomized configurations
// compared against a modular-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_tz_hour_scheduler;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [4:0]     utc_hour;
   logic           tick;
   logic           mode_btn;
   logic           cfg_we;
   logic [1:0]     cfg_idx;
   logic [4:0]     cfg_offset;
   logic           mode_12h;
   logic [5*N-1:0] hour_disp;
   logic [N-1:0]   is_pm;
   logic [2*N-1:0] day_off;
   logic           busy;
   logic           done;

   tz_hour_scheduler #(.N_CITY(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .utc_hour   (utc_hour),
      .tick       (tick),
      .mode_btn   (mode_btn),
      .cfg_we     (cfg_we),
      .cfg_idx    (cfg_idx),
      .cfg_offset (cfg_offset),
      .mode_12h   (mode_12h),
      .hour_disp  (hour_disp),
      .is_pm      (is_pm),
      .day_off    (day_off),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state.
   int m_off [N];
   int m_utc;
   bit m_mode;

   typedef struct packed {
      logic [4:0]      utc;
      logic            mode12;
      logic [3:0][4:0] off;    // slot3..slot0, two's complement
      logic [3:0][4:0] disp;
      logic [3:0]      pm;
      logic [3:0][1:0] day;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int m_local(input int u, input int off);
      int uu = (u >= 24) ? 0 : u;
      return ((uu + off) % 24 + 24) % 24;
   endfunction

   function automatic int m_day(input int u, input int off);
      int uu = (u >= 24) ? 0 : u;
      int s  = uu + off;
      return (s < 0) ? -1 : s / 24;
   endfunction

   task automatic check_slots(input string tag);
      for (int k = 0; k < N; k++) begin
         int l  = m_local(m_utc, m_off[k]);
         int ed = (m_mode && l > 12) ? l - 12 : l;
         int ep = (m_mode && l >= 12) ? 1 : 0;
         check($sformatf("%s_disp%0d", tag, k), int'(hour_disp[5*k +: 5]), ed);
         check($sformatf("%s_pm%0d", tag, k), int'(is_pm[k]), ep);
         check($sformatf("%s_day%0d", tag, k), int'($signed(day_off[2*k +: 2])),
               m_day(m_utc, m_off[k]));
      end
   endtask

   task automatic wait_done(input int budget, output int cycles);
      cycles = 0;
      do begin
         step();
         cycles++;
      end while (!done && cycles < budget);
      if (!done) check("done_timeout", int'(done), 1);
   endtask

   task automatic wait_idle(input string tag);
      int c = 0;
      while (busy && c < 60) begin
         step();
         c++;
      end
      check($sformatf("%s_idle", tag), int'(busy), 0);
   endtask

   task automatic clear_inputs();
      tick = 1'b0; mode_btn = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_offset = '0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_disp"}, int'(hour_disp), 0);
      check({tag, "_pm"}, int'(is_pm), 0);
      check({tag, "_day"}, int'(day_off), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_mode"}, int'(mode_12h), 0);
   endtask

   initial begin
      int cyc;
      int dcount;
      int first_i;
      int second_i;

      // ----------------------------------------------------------------- vectors
      vecs[0] = '{utc: 5'd20, mode12: 1'b0,
                  off:  {5'(14), 5'(-5), 5'(9), 5'(0)},
                  disp: {5'd10, 5'd15, 5'd5, 5'd20}, pm: 4'b0000,
                  day:  {2'b01, 2'b00, 2'b01, 2'b00}};
      vecs[1] = '{utc: 5'd20, mode12: 1'b1,
                  off:  {5'(14), 5'(-5), 5'(9), 5'(0)},
                  disp: {5'd10, 5'd3, 5'd5, 5'd8}, pm: 4'b0101,
                  day:  {2'b01, 2'b00, 2'b01, 2'b00}};
      vecs[2] = '{utc: 5'd3, mode12: 1'b0,
                  off:  {5'(0), 5'(0), 5'(0), 5'(-12)},
                  disp: {5'd3, 5'd3, 5'd3, 5'd15}, pm: 4'b0000,
                  day:  {2'b00, 2'b00, 2'b00, 2'b11}};
      vecs[3] = '{utc: 5'd12, mode12: 1'b1,
                  off:  {5'(0), 5'(0), 5'(0), 5'(0)},
                  disp: {5'd12, 5'd12, 5'd12, 5'd12}, pm: 4'b1111,
                  day:  {2'b00, 2'b00, 2'b00, 2'b00}};
      vecs[4] = '{utc: 5'd0, mode12: 1'b1,
                  off:  {5'(0), 5'(0), 5'(0), 5'(0)},
                  disp: {5'd0, 5'd0, 5'd0, 5'd0}, pm: 4'b0000,
                  day:  {2'b00, 2'b00, 2'b00, 2'b00}};
      vecs[5] = '{utc: 5'd23, mode12: 1'b1,
                  off:  {5'(-1), 5'(1), 5'(-12), 5'(14)},
                  disp: {5'd10, 5'd0, 5'd11, 5'd1}, pm: 4'b1001,
                  day:  {2'b00, 2'b01, 2'b00, 2'b01}};
      vecs[6] = '{utc: 5'd30, mode12: 1'b0,
                  off:  {5'(0), 5'(5), 5'(-1), 5'(0)},
                  disp: {5'd0, 5'd5, 5'd23, 5'd0}, pm: 4'b0000,
                  day:  {2'b00, 2'b00, 2'b11, 2'b00}};

      // ------------------------------------------------------ reset + first sweep
      rst = 1'b1;
      utc_hour = 5'd7;
      clear_inputs();
      for (int k = 0; k < N; k++) m_off[k] = 0;
      m_mode = 1'b0;
      m_utc  = 7;
      repeat (3) step();
      check_all_zero("reset");

      rst = 1'b0;
      step();
      check("post_reset_busy", int'(busy), 1);
      cyc = 1;
      while (!done && cyc < 20) begin
         step();
         cyc++;
      end
      check("post_reset_latency", cyc, N + 1);
      check_slots("post_reset");
      step();
      check("post_reset_done_pulse", int'(done), 0);
      check("post_reset_busy_end", int'(busy), 0);

      // ------------------------------------------------------ table-driven vectors
      for (int i = 0; i < 7; i++) begin
         utc_hour = vecs[i].utc;
         tick     = 1'b1;
         mode_btn = (vecs[i].mode12 != m_mode);
         step();
         clear_inputs();
         for (int k = 0; k < N; k++) begin
            cfg_we     = 1'b1;
            cfg_idx    = 2'(k);
            cfg_offset = vecs[i].off[k];
            step();
         end
         clear_inputs();
         wait_idle($sformatf("vec%0d", i));
         check($sformatf("vec%0d_mode", i), int'(mode_12h), int'(vecs[i].mode12));
         for (int k = 0; k < N; k++) begin
            check($sformatf("vec%0d_disp%0d", i, k), int'(hour_disp[5*k +: 5]),
                  int'(vecs[i].disp[k]));
            check($sformatf("vec%0d_pm%0d", i, k), int'(is_pm[k]), int'(vecs[i].pm[k]));
            check($sformatf("vec%0d_day%0d", i, k), int'(day_off[2*k +: 2]),
                  int'(vecs[i].day[k]));
         end
         m_mode = vecs[i].mode12;
         m_utc  = int'(vecs[i].utc);
         for (int k = 0; k < N; k++) m_off[k] = int'($signed(vecs[i].off[k]));
      end

      // ------------------------------------------------------ invalid config writes
      cfg_we = 1'b1; cfg_idx = 2'd1; cfg_offset = 5'(15);
      step();
      clear_inputs();
      check("inv_hi_busy0", int'(busy), 0);
      step();
      check("inv_hi_busy1", int'(busy), 0);
      cfg_we = 1'b1; cfg_idx = 2'd2; cfg_offset = 5'(-13);
      step();
      clear_inputs();
      check("inv_lo_busy0", int'(busy), 0);
      step();
      check("inv_lo_busy1", int'(busy), 0);
      utc_hour = 5'd9; tick = 1'b1;
      step();
      clear_inputs();
      m_utc = 9;
      wait_idle("inv_sweep");
      check_slots("inv_table");

      // ------------------------------------------------------ simultaneous events
      utc_hour = 5'd17; tick = 1'b1; mode_btn = 1'b1;
      cfg_we = 1'b1; cfg_idx = 2'd3; cfg_offset = 5'(-8);
      step();
      clear_inputs();
      m_utc = 17; m_mode = ~m_mode; m_off[3] = -8;
      dcount = 0;
      for (int i = 0; i < 20; i++) begin
         if (done) dcount++;
         step();
      end
      check("simul_one_sweep", dcount, 1);
      check_slots("simul");

      // ------------------------------------------------------ trigger during sweep
      utc_hour = 5'd5; tick = 1'b1;
      step();
      clear_inputs();
      check("tds_busy_T", int'(busy), 1);
      utc_hour = 5'd9; tick = 1'b1;      // lands on CALC cycle 1
      step();
      clear_inputs();
      first_i = -1; second_i = -1; dcount = 0;
      for (int i = 0; i < 20; i++) begin
         if (done) begin
            dcount++;
            if (first_i < 0) first_i = i;
            else if (second_i < 0) second_i = i;
         end
         step();
      end
      check("tds_two_dones", dcount, 2);
      check("tds_gap", second_i - first_i, N + 1);
      m_utc = 9;
      check_slots("tds");

      // ------------------------------------------------------ randomized vs model
      for (int i = 0; i < 24; i++) begin
         int u   = int'($urandom_range(0, 31));
         int k   = int'($urandom_range(0, N - 1));
         int off = int'($urandom_range(0, 26)) - 12;
         bit press = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 4) == 0) off = ($urandom_range(0, 1) != 0) ? 15 : -13;
         utc_hour = 5'(u); tick = 1'b1; mode_btn = press;
         cfg_we = 1'b1; cfg_idx = 2'(k); cfg_offset = 5'(off);
         step();
         clear_inputs();
         m_utc = u;
         m_mode ^= press;
         if (off >= -12 && off <= 14) m_off[k] = off;
         wait_idle($sformatf("rnd%0d", i));
         check($sformatf("rnd%0d_mode", i), int'(mode_12h), int'(m_mode));
         check_slots($sformatf("rnd%0d", i));
      end

      // ------------------------------------------------------ reset mid-sweep
      utc_hour = 5'd15; tick = 1'b1;
      step();
      clear_inputs();
      step();                            // now in CALC cycle 2
      rst = 1'b1;
      step();
      check_all_zero("mid_reset");
      rst = 1'b0;
      for (int k = 0; k < N; k++) m_off[k] = 0;
      m_mode = 1'b0;
      m_utc  = 15;
      wait_done(20, cyc);
      check("mid_reset_latency", cyc, N + 1);
      check_slots("mid_reset_restore");
      step();
      check("mid_reset_done_pulse", int'(done), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
